// File: rtl/procyon_mhq_pkg.sv
// Shared definitions for the Miss Handling Queue.
//   - LSU function encodings (only defined here if the surrounding codebase
//     has not already provided them)
//   - fill FSM state enum
//   - MHQ entry record
//   - byte-mask to bit-mask expansion helper
// No ports; imported by procyon_mhq and used by procyon_mhq_lookup.

`ifndef PCYN_LSU_FUNC_WIDTH
`define PCYN_LSU_FUNC_WIDTH 4
`define PCYN_LSU_FUNC_LB    4'b0000
`define PCYN_LSU_FUNC_LH    4'b0001
`define PCYN_LSU_FUNC_LW    4'b0010
`define PCYN_LSU_FUNC_LBU   4'b0011
`define PCYN_LSU_FUNC_LHU   4'b0100
`define PCYN_LSU_FUNC_SB    4'b0101
`define PCYN_LSU_FUNC_SH    4'b0110
`define PCYN_LSU_FUNC_SW    4'b0111
`define PCYN_LSU_FUNC_FENCE 4'b1000
`endif

package procyon_mhq_pkg;

    localparam int MHQ_ADDR_WIDTH = 32;
    localparam int MHQ_LINE_SIZE  = 32;
    localparam int MHQ_LINE_WIDTH = MHQ_LINE_SIZE * 8;

    typedef enum logic [1:0] {
        MHQ_STATE_IDLE = 2'b00,
        MHQ_STATE_REQ  = 2'b01,
        MHQ_STATE_FILL = 2'b10
    } mhq_state_t;

    // One outstanding line miss. mask marks bytes written by merged stores;
    // data is only meaningful where mask is set.
    typedef struct packed {
        logic                      valid;
        logic [MHQ_ADDR_WIDTH-1:0] addr;
        logic [MHQ_LINE_WIDTH-1:0] data;
        logic [MHQ_LINE_SIZE-1:0]  mask;
        logic                      dirty;
    } mhq_entry_t;

    // Widen a per-byte mask into a per-bit mask for the line.
    function automatic logic [MHQ_LINE_WIDTH-1:0] mhq_expand_mask(
        input logic [MHQ_LINE_SIZE-1:0] byte_mask
    );
        logic [MHQ_LINE_WIDTH-1:0] bit_mask;
        bit_mask = '0;
        for (int i = 0; i < MHQ_LINE_SIZE; i++) begin
            bit_mask[i*8 +: 8] = {8{byte_mask[i]}};
        end
        return bit_mask;
    endfunction

endpackage

// File: rtl/procyon_mhq_lookup.sv
// Combinational lookup datapath for one LSU op against the MHQ.
// Ports:
//   i_entry_valid / i_entry_addr : per-entry valid bits and line addresses
//   i_addr, i_lsu_func, i_data   : the op's byte address, LSU function, store data
//   o_line_addr                  : op address with line offset cleared
//   o_match                      : one-hot (at most) vector of matching valid entries
//   o_hit_idx                    : index of the matching entry (0 if none)
//   o_byte_mask                  : bytes of the line written by the op (SB/SH/SW)
//   o_line_data                  : store data shifted to its byte offset in the line

module procyon_mhq_lookup #(
    parameter  OPTN_DATA_WIDTH    = 32,
    parameter  OPTN_ADDR_WIDTH    = 32,
    parameter  OPTN_DC_LINE_SIZE  = 32,
    parameter  OPTN_MHQ_DEPTH     = 4,
    parameter  OPTN_MHQ_IDX_WIDTH = 2,
    localparam DC_LINE_WIDTH      = OPTN_DC_LINE_SIZE * 8
) (
    input  logic [OPTN_MHQ_DEPTH-1:0]       i_entry_valid,
    input  logic [OPTN_ADDR_WIDTH-1:0]      i_entry_addr [OPTN_MHQ_DEPTH],
    input  logic [OPTN_ADDR_WIDTH-1:0]      i_addr,
    input  logic [`PCYN_LSU_FUNC_WIDTH-1:0] i_lsu_func,
    input  logic [OPTN_DATA_WIDTH-1:0]      i_data,
    output logic [OPTN_ADDR_WIDTH-1:0]      o_line_addr,
    output logic [OPTN_MHQ_DEPTH-1:0]       o_match,
    output logic [OPTN_MHQ_IDX_WIDTH-1:0]   o_hit_idx,
    output logic [OPTN_DC_LINE_SIZE-1:0]    o_byte_mask,
    output logic [DC_LINE_WIDTH-1:0]        o_line_data
);

    localparam OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE);
    localparam DATA_BYTES   = OPTN_DATA_WIDTH / 8;

    logic [OFFSET_WIDTH-1:0] offset;
    logic [DATA_BYTES-1:0]   size_mask;

    assign offset      = i_addr[OFFSET_WIDTH-1:0];
    assign o_line_addr = {i_addr[OPTN_ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};

    genvar gi;
    generate
        for (gi = 0; gi < OPTN_MHQ_DEPTH; gi++) begin : gen_match
            assign o_match[gi] = i_entry_valid[gi] & (i_entry_addr[gi] == o_line_addr);
        end
    endgenerate

    // Line addresses in the queue are unique, so at most one bit is set.
    always_comb begin
        o_hit_idx = '0;
        for (int i = 0; i < OPTN_MHQ_DEPTH; i++) begin
            if (o_match[i]) begin
                o_hit_idx = OPTN_MHQ_IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        size_mask = '1;
        case (i_lsu_func)
            `PCYN_LSU_FUNC_SB: size_mask = DATA_BYTES'(1);
            `PCYN_LSU_FUNC_SH: size_mask = DATA_BYTES'(3);
            default:           size_mask = '1;
        endcase
    end

    // Ops are naturally aligned, so the shifted mask never crosses the line.
    assign o_byte_mask = {{(OPTN_DC_LINE_SIZE-DATA_BYTES){1'b0}}, size_mask} << offset;
    assign o_line_data = {{(DC_LINE_WIDTH-OPTN_DATA_WIDTH){1'b0}}, i_data} << {offset, 3'b000};

endmodule

// File: rtl/procyon_mhq.sv
// Miss Handling Queue: FIFO of outstanding D$ line misses.
// Ports:
//   clk, n_rst                : clock, synchronous active-low reset
//   i_mhq_lookup_*            : LSU D1 op (valid, dc_hit, addr, func, data, we)
//   o_mhq_lookup_retry/_tag   : registered response, valid the cycle after lookup
//   o_mhq_fill_*              : one-cycle fill of the merged head line to the LSU
//   o_ccu_en/_addr            : level line-read request to the CCU
//   i_ccu_done/_data          : CCU completion pulse with line data

module procyon_mhq
    import procyon_mhq_pkg::*;
#(
    parameter  OPTN_DATA_WIDTH    = 32,
    parameter  OPTN_ADDR_WIDTH    = MHQ_ADDR_WIDTH,
    parameter  OPTN_DC_LINE_SIZE  = MHQ_LINE_SIZE,
    parameter  OPTN_MHQ_DEPTH     = 4,
    parameter  OPTN_MHQ_IDX_WIDTH = 2,
    localparam DC_LINE_WIDTH      = OPTN_DC_LINE_SIZE * 8
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            i_mhq_lookup_valid,
    input  logic                            i_mhq_lookup_dc_hit,
    input  logic [OPTN_ADDR_WIDTH-1:0]      i_mhq_lookup_addr,
    input  logic [`PCYN_LSU_FUNC_WIDTH-1:0] i_mhq_lookup_lsu_func,
    input  logic [OPTN_DATA_WIDTH-1:0]      i_mhq_lookup_data,
    input  logic                            i_mhq_lookup_we,
    output logic                            o_mhq_lookup_retry,
    output logic [OPTN_MHQ_IDX_WIDTH-1:0]   o_mhq_lookup_tag,
    output logic                            o_mhq_fill_en,
    output logic [OPTN_ADDR_WIDTH-1:0]      o_mhq_fill_addr,
    output logic [OPTN_MHQ_IDX_WIDTH-1:0]   o_mhq_fill_tag,
    output logic [DC_LINE_WIDTH-1:0]        o_mhq_fill_data,
    output logic                            o_mhq_fill_dirty,
    output logic                            o_ccu_en,
    output logic [OPTN_ADDR_WIDTH-1:0]      o_ccu_addr,
    input  logic                            i_ccu_done,
    input  logic [DC_LINE_WIDTH-1:0]        i_ccu_data
);

    mhq_entry_t                    entry_reg [OPTN_MHQ_DEPTH];
    mhq_state_t                    state_reg;
    logic [OPTN_MHQ_IDX_WIDTH-1:0] head_reg;
    logic [OPTN_MHQ_IDX_WIDTH-1:0] tail_reg;
    logic [OPTN_MHQ_IDX_WIDTH:0]   count_reg;
    logic [DC_LINE_WIDTH-1:0]      fill_buf_reg;
    logic                          retry_reg;
    logic [OPTN_MHQ_IDX_WIDTH-1:0] tag_reg;

    logic [OPTN_MHQ_DEPTH-1:0]     entry_valid;
    logic [OPTN_ADDR_WIDTH-1:0]    entry_addr [OPTN_MHQ_DEPTH];
    mhq_entry_t                    head_entry;

    logic [OPTN_ADDR_WIDTH-1:0]    lk_line_addr;
    logic [OPTN_MHQ_DEPTH-1:0]     lk_match;
    logic [OPTN_MHQ_IDX_WIDTH-1:0] lk_hit_idx;
    logic [OPTN_DC_LINE_SIZE-1:0]  lk_byte_mask;
    logic [DC_LINE_WIDTH-1:0]      lk_line_data;
    logic [DC_LINE_WIDTH-1:0]      lk_bit_mask;
    logic [DC_LINE_WIDTH-1:0]      head_bit_mask;

    logic lk_act;
    logic lk_hit;
    logic head_fill_hit;
    logic full;
    logic alloc_en;
    logic merge_en;
    logic deq_en;
    logic retry_next;
    logic [OPTN_MHQ_IDX_WIDTH-1:0] tag_next;

    genvar gi;
    generate
        for (gi = 0; gi < OPTN_MHQ_DEPTH; gi++) begin : gen_entry_view
            assign entry_valid[gi] = entry_reg[gi].valid;
            assign entry_addr[gi]  = entry_reg[gi].addr;
        end
    endgenerate

    assign head_entry = entry_reg[head_reg];

    procyon_mhq_lookup #(
        .OPTN_DATA_WIDTH    (OPTN_DATA_WIDTH),
        .OPTN_ADDR_WIDTH    (OPTN_ADDR_WIDTH),
        .OPTN_DC_LINE_SIZE  (OPTN_DC_LINE_SIZE),
        .OPTN_MHQ_DEPTH     (OPTN_MHQ_DEPTH),
        .OPTN_MHQ_IDX_WIDTH (OPTN_MHQ_IDX_WIDTH)
    ) u_lookup (
        .i_entry_valid (entry_valid),
        .i_entry_addr  (entry_addr),
        .i_addr        (i_mhq_lookup_addr),
        .i_lsu_func    (i_mhq_lookup_lsu_func),
        .i_data        (i_mhq_lookup_data),
        .o_line_addr   (lk_line_addr),
        .o_match       (lk_match),
        .o_hit_idx     (lk_hit_idx),
        .o_byte_mask   (lk_byte_mask),
        .o_line_data   (lk_line_data)
    );

    assign lk_bit_mask   = mhq_expand_mask(lk_byte_mask);
    assign head_bit_mask = mhq_expand_mask(head_entry.mask);

    assign lk_act = i_mhq_lookup_valid & ~i_mhq_lookup_dc_hit;
    assign lk_hit = |lk_match;
    assign full   = (count_reg == (OPTN_MHQ_IDX_WIDTH+1)'(OPTN_MHQ_DEPTH));
    assign deq_en = (state_reg == MHQ_STATE_FILL);

    // The head line is being handed to the LSU this cycle; a merge now would
    // be lost, so the op must replay and find the line in the cache.
    assign head_fill_hit = lk_hit & (lk_hit_idx == head_reg) & (state_reg == MHQ_STATE_FILL);

    // Fullness uses the current count: a same-cycle dequeue frees nothing yet.
    assign alloc_en   = lk_act & ~lk_hit & ~full;
    assign merge_en   = lk_act & lk_hit & ~head_fill_hit & i_mhq_lookup_we;
    assign retry_next = lk_act & (head_fill_hit | (~lk_hit & full));
    assign tag_next   = (lk_act & ~retry_next) ? (lk_hit ? lk_hit_idx : tail_reg) : '0;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < OPTN_MHQ_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OPTN_MHQ_DEPTH; i++) begin
                if (alloc_en && (tail_reg == OPTN_MHQ_IDX_WIDTH'(i))) begin
                    entry_reg[i].valid <= 1'b1;
                    entry_reg[i].addr  <= lk_line_addr;
                    entry_reg[i].data  <= i_mhq_lookup_we ? (lk_line_data & lk_bit_mask) : '0;
                    entry_reg[i].mask  <= i_mhq_lookup_we ? lk_byte_mask : '0;
                    entry_reg[i].dirty <= i_mhq_lookup_we;
                end else if (merge_en && (lk_hit_idx == OPTN_MHQ_IDX_WIDTH'(i))) begin
                    entry_reg[i].data  <= (entry_reg[i].data & ~lk_bit_mask) | (lk_line_data & lk_bit_mask);
                    entry_reg[i].mask  <= entry_reg[i].mask | lk_byte_mask;
                    entry_reg[i].dirty <= 1'b1;
                end else if (deq_en && (head_reg == OPTN_MHQ_IDX_WIDTH'(i))) begin
                    entry_reg[i].valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg    <= MHQ_STATE_IDLE;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            fill_buf_reg <= '0;
            retry_reg    <= 1'b0;
            tag_reg      <= '0;
        end else begin
            retry_reg <= retry_next;
            tag_reg   <= tag_next;
            if (alloc_en) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (deq_en) begin
                head_reg <= head_reg + 1'b1;
            end
            count_reg <= count_reg + {{OPTN_MHQ_IDX_WIDTH{1'b0}}, alloc_en}
                                   - {{OPTN_MHQ_IDX_WIDTH{1'b0}}, deq_en};
            case (state_reg)
                MHQ_STATE_IDLE: begin
                    if (head_entry.valid) begin
                        state_reg <= MHQ_STATE_REQ;
                    end
                end
                MHQ_STATE_REQ: begin
                    if (i_ccu_done) begin
                        fill_buf_reg <= i_ccu_data;
                        state_reg    <= MHQ_STATE_FILL;
                    end
                end
                MHQ_STATE_FILL: begin
                    state_reg <= MHQ_STATE_IDLE;
                end
                default: begin
                    state_reg <= MHQ_STATE_IDLE;
                end
            endcase
        end
    end

    assign o_mhq_lookup_retry = retry_reg;
    assign o_mhq_lookup_tag   = tag_reg;

    assign o_ccu_en   = (state_reg == MHQ_STATE_REQ);
    assign o_ccu_addr = o_ccu_en ? head_entry.addr : '0;

    // Store bytes collected while the miss was pending override CCU data.
    assign o_mhq_fill_en    = deq_en;
    assign o_mhq_fill_addr  = deq_en ? head_entry.addr : '0;
    assign o_mhq_fill_tag   = deq_en ? head_reg : '0;
    assign o_mhq_fill_data  = deq_en ? ((fill_buf_reg & ~head_bit_mask) | (head_entry.data & head_bit_mask)) : '0;
    assign o_mhq_fill_dirty = deq_en & head_entry.dirty;

endmodule

// File: tb/tb_procyon_mhq.sv
module tb_procyon_mhq;
    import procyon_mhq_pkg::*;

    localparam AW = 32;
    localparam DW = 32;
    localparam LW = 256;
    localparam IW = 2;

    logic                            clk = 1'b0;
    logic                            n_rst = 1'b0;
    logic                            i_mhq_lookup_valid = 1'b0;
    logic                            i_mhq_lookup_dc_hit = 1'b0;
    logic [AW-1:0]                   i_mhq_lookup_addr = '0;
    logic [`PCYN_LSU_FUNC_WIDTH-1:0] i_mhq_lookup_lsu_func = '0;
    logic [DW-1:0]                   i_mhq_lookup_data = '0;
    logic                            i_mhq_lookup_we = 1'b0;
    logic                            o_mhq_lookup_retry;
    logic [IW-1:0]                   o_mhq_lookup_tag;
    logic                            o_mhq_fill_en;
    logic [AW-1:0]                   o_mhq_fill_addr;
    logic [IW-1:0]                   o_mhq_fill_tag;
    logic [LW-1:0]                   o_mhq_fill_data;
    logic                            o_mhq_fill_dirty;
    logic                            o_ccu_en;
    logic [AW-1:0]                   o_ccu_addr;
    logic                            i_ccu_done = 1'b0;
    logic [LW-1:0]                   i_ccu_data = '0;

    always #5 clk = ~clk;

    procyon_mhq dut (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .i_mhq_lookup_valid    (i_mhq_lookup_valid),
        .i_mhq_lookup_dc_hit   (i_mhq_lookup_dc_hit),
        .i_mhq_lookup_addr     (i_mhq_lookup_addr),
        .i_mhq_lookup_lsu_func (i_mhq_lookup_lsu_func),
        .i_mhq_lookup_data     (i_mhq_lookup_data),
        .i_mhq_lookup_we       (i_mhq_lookup_we),
        .o_mhq_lookup_retry    (o_mhq_lookup_retry),
        .o_mhq_lookup_tag      (o_mhq_lookup_tag),
        .o_mhq_fill_en         (o_mhq_fill_en),
        .o_mhq_fill_addr       (o_mhq_fill_addr),
        .o_mhq_fill_tag        (o_mhq_fill_tag),
        .o_mhq_fill_data       (o_mhq_fill_data),
        .o_mhq_fill_dirty      (o_mhq_fill_dirty),
        .o_ccu_en              (o_ccu_en),
        .o_ccu_addr            (o_ccu_addr),
        .i_ccu_done            (i_ccu_done),
        .i_ccu_data            (i_ccu_data)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          retry;
        logic [IW-1:0] tag;
        logic          chk_tag;
    } lk_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] tag;
        logic [LW-1:0] data;
        logic          dirty;
    } fill_exp_t;

    lk_exp_t       lk_q[$];
    fill_exp_t     fill_q[$];
    logic [AW-1:0] ccu_q[$];
    lk_exp_t       lk_e;
    fill_exp_t     fill_e;
    logic [AW-1:0] ccu_e;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] fill_line(input logic [7:0] b);
        logic [LW-1:0] r;
        for (int i = 0; i < LW/8; i++) r[i*8 +: 8] = b;
        return r;
    endfunction

    // ---------------- monitor ----------------
    logic lk_issued = 1'b0;
    logic ccu_prev  = 1'b0;

    always @(posedge clk) lk_issued <= i_mhq_lookup_valid & n_rst;

    always @(negedge clk) begin
        if (lk_issued) begin
            if (lk_q.size() == 0) begin
                chk("lookup_unexpected", 1, 0);
            end else begin
                lk_e = lk_q.pop_front();
                chk("lookup_retry", o_mhq_lookup_retry, lk_e.retry);
                if (lk_e.chk_tag) chk("lookup_tag", o_mhq_lookup_tag, lk_e.tag);
                $display("lookup addr=%08h retry=%0b tag=%0d", lk_e.addr, o_mhq_lookup_retry, o_mhq_lookup_tag);
            end
        end
        if (o_mhq_fill_en) begin
            if (fill_q.size() == 0) begin
                chk("fill_unexpected", 1, 0);
            end else begin
                fill_e = fill_q.pop_front();
                chk("fill_addr", o_mhq_fill_addr, fill_e.addr);
                chk("fill_tag", o_mhq_fill_tag, fill_e.tag);
                chk("fill_data", o_mhq_fill_data, fill_e.data);
                chk("fill_dirty", o_mhq_fill_dirty, fill_e.dirty);
                $display("fill addr=%08h tag=%0d dirty=%0b", o_mhq_fill_addr, o_mhq_fill_tag, o_mhq_fill_dirty);
            end
        end
        if (o_ccu_en && !ccu_prev) begin
            if (ccu_q.size() == 0) begin
                chk("ccu_unexpected", 1, 0);
            end else begin
                ccu_e = ccu_q.pop_front();
                chk("ccu_addr", o_ccu_addr, ccu_e);
                $display("ccu request addr=%08h", o_ccu_addr);
            end
        end
        ccu_prev = o_ccu_en;
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [AW-1:0] addr, input logic [`PCYN_LSU_FUNC_WIDTH-1:0] func,
                          input logic [DW-1:0] data, input logic we, input logic hit,
                          input logic exp_retry, input logic [IW-1:0] exp_tag, input logic chk_tag);
        lk_exp_t e;
        e.addr = addr; e.retry = exp_retry; e.tag = exp_tag; e.chk_tag = chk_tag;
        lk_q.push_back(e);
        i_mhq_lookup_valid    = 1'b1;
        i_mhq_lookup_dc_hit   = hit;
        i_mhq_lookup_addr     = addr;
        i_mhq_lookup_lsu_func = func;
        i_mhq_lookup_data     = data;
        i_mhq_lookup_we       = we;
        tick;
        i_mhq_lookup_valid  = 1'b0;
        i_mhq_lookup_dc_hit = 1'b0;
        i_mhq_lookup_we     = 1'b0;
    endtask

    task automatic push_fill(input logic [AW-1:0] addr, input logic [IW-1:0] tag,
                             input logic [LW-1:0] data, input logic dirty);
        fill_exp_t f;
        f.addr = addr; f.tag = tag; f.data = data; f.dirty = dirty;
        fill_q.push_back(f);
    endtask

    task automatic wait_ccu;
        for (int i = 0; i < 20 && o_ccu_en !== 1'b1; i++) tick;
        chk("ccu_wait", o_ccu_en, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [LW-1:0] exp_line;

    initial begin
        // reset state
        n_rst = 1'b0;
        repeat (3) tick;
        chk("rst_retry", o_mhq_lookup_retry, 0);
        chk("rst_tag", o_mhq_lookup_tag, 0);
        chk("rst_fill_en", o_mhq_fill_en, 0);
        chk("rst_fill_addr", o_mhq_fill_addr, 0);
        chk("rst_fill_data", o_mhq_fill_data, 0);
        chk("rst_fill_dirty", o_mhq_fill_dirty, 0);
        chk("rst_ccu_en", o_ccu_en, 0);
        chk("rst_ccu_addr", o_ccu_addr, 0);
        n_rst = 1'b1;

        // first miss, then request appears two cycles after the lookup
        ccu_q.push_back(32'h0000_1000);
        lookup(32'h0000_1004, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        chk("ccu_en_early", o_ccu_en, 0);
        tick;
        chk("ccu_en_lat2", o_ccu_en, 1);
        chk("ccu_addr_lat2", o_ccu_addr, 32'h0000_1000);

        // same-line load and store merges while entry 0 is in REQ
        lookup(32'h0000_1018, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        lookup(32'h0000_1001, `PCYN_LSU_FUNC_SB, 32'hFFFF_FFAB, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        lookup(32'h0000_1006, `PCYN_LSU_FUNC_SH, 32'hFFFF_1234, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        lookup(32'h0000_1008, `PCYN_LSU_FUNC_SW, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);

        exp_line = fill_line(8'h11);
        exp_line[1*8 +: 8]   = 8'hAB;
        exp_line[6*8 +: 16]  = 16'h1234;
        exp_line[8*8 +: 32]  = 32'hDEAD_BEEF;
        exp_line[28*8 +: 32] = 32'hCAFE_F00D;
        push_fill(32'h0000_1000, 2'd0, exp_line, 1'b1);

        // CCU completes in the same cycle as a merge to the head
        i_ccu_done = 1'b1;
        i_ccu_data = fill_line(8'h11);
        lookup(32'h0000_101C, `PCYN_LSU_FUNC_SW, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        i_ccu_done = 1'b0;
        i_ccu_data = '0;

        // FILL cycle: hit on the head must replay
        chk("fill_pulse", o_mhq_fill_en, 1);
        lookup(32'h0000_1010, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        chk("fill_one_cycle", o_mhq_fill_en, 0);

        // D$ hit does nothing; next miss lands in entry 1
        lookup(32'h0000_7000, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        ccu_q.push_back(32'h0000_8000);
        lookup(32'h0000_8000, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
        wait_ccu;

        // reset during REQ drops the request; a late done is ignored
        n_rst = 1'b0;
        tick;
        chk("rst_req_ccu_en", o_ccu_en, 0);
        chk("rst_req_ccu_addr", o_ccu_addr, 0);
        n_rst = 1'b1;
        i_ccu_done = 1'b1;
        i_ccu_data = fill_line(8'h99);
        tick;
        i_ccu_done = 1'b0;
        i_ccu_data = '0;
        repeat (3) tick;
        chk("late_done_no_fill", o_mhq_fill_en, 0);
        chk("late_done_no_req", o_ccu_en, 0);

        // fill the queue, overflow, and wrap the tail
        n_rst = 1'b0;
        repeat (2) tick;
        n_rst = 1'b1;
        ccu_q.push_back(32'h0000_2000);
        lookup(32'h0000_2000, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        lookup(32'h0000_3000, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
        lookup(32'h0000_4000, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
        lookup(32'h0000_5000, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1);
        lookup(32'h0000_6000, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        wait_ccu;
        push_fill(32'h0000_2000, 2'd0, fill_line(8'h22), 1'b0);
        i_ccu_done = 1'b1;
        i_ccu_data = fill_line(8'h22);
        tick;
        i_ccu_done = 1'b0;
        i_ccu_data = '0;
        // dequeue in this cycle does not free a slot yet
        lookup(32'h0000_6000, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        ccu_q.push_back(32'h0000_3000);
        lookup(32'h0000_6000, `PCYN_LSU_FUNC_LW, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        wait_ccu;
        push_fill(32'h0000_3000, 2'd1, fill_line(8'h33), 1'b0);
        i_ccu_done = 1'b1;
        i_ccu_data = fill_line(8'h33);
        tick;
        i_ccu_done = 1'b0;
        i_ccu_data = '0;
        ccu_q.push_back(32'h0000_4000);
        repeat (4) tick;

        chk("lookup_q_drained", lk_q.size(), 0);
        chk("fill_q_drained", fill_q.size(), 0);
        chk("ccu_q_drained", ccu_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
